mem_port_arbiter: RTL and testbench

// Shares one single-ported memory (valid/ready, response data in the completing cycle) between the

---
 rtl/mem_port_arbiter.sv | 89 ++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported valid/ready memory between the fetch and the load/store unit.
// Grants combinationally. The grant is held until the memory completes, and fetch starvation is bounded.
//   state  | meaning
//   IDLE   | no locked request, arbitrate this cycle
//   LOCK_I | fetch request issued but not yet accepted, grant pinned to fetch
//   LOCK_D | data request issued but not yet accepted, grant pinned to data
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_i,
    output logic              i_ready_o,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_valid_i,
    output logic              d_ready_o,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [3:0]        d_we_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              gnt_d_o
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t        state_q, state_d;
    logic          gnt_d_q, gnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_valid, i_done, d_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_d_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_d_q  <= gnt_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        gnt_d    = gnt_d_q;
        state_d  = IDLE;
        streak_d = streak_q;

        case (state_q)
            LOCK_I:  gnt_d = 1'b0;
            LOCK_D:  gnt_d = 1'b1;
            default: begin
                if (d_valid_i && i_valid_i) gnt_d = (streak_q < LIMIT);
                else if (d_valid_i)         gnt_d = 1'b1;
                else if (i_valid_i)         gnt_d = 1'b0;
            end
        endcase

        // Reset gates the request combinationally so nothing completes while rst is high.
        mem_valid = !rst && (gnt_d ? d_valid_i : i_valid_i);
        i_done    = mem_valid && mem_ready_i && !gnt_d;
        d_done    = mem_valid && mem_ready_i && gnt_d;

        if (mem_valid && !mem_ready_i) state_d = gnt_d ? LOCK_D : LOCK_I;

        if (!i_valid_i || i_done)           streak_d = '0;
        else if (d_done && streak_q < LIMIT) streak_d = streak_q + 1'b1;
    end

    assign mem_valid_o = mem_valid;
    assign mem_addr_o  = gnt_d ? d_addr_i : i_addr_i;
    assign mem_wdata_o = gnt_d ? d_wdata_i : '0;
    assign mem_we_o    = gnt_d ? d_we_i : 4'h0;
    assign i_ready_o   = i_done;
    assign d_ready_o   = d_done;
    assign i_rdata_o   = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;
    assign gnt_d_o     = gnt_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the single-cycle behaviour,
// plus sequences for reset and STARVE_LIMIT=0.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, d_valid, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_we;

    logic        i_ready, d_ready, mem_valid, gnt_d;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        z_i_ready, z_d_ready, z_mem_valid, z_gnt_d;
    logic [31:0] z_i_rdata, z_d_rdata, z_mem_addr, z_mem_wdata;
    logic [3:0]  z_mem_we;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) u4 (
        .clk(clk), .rst(rst),
        .i_valid_i(i_valid), .i_ready_o(i_ready), .i_addr_i(i_addr), .i_rdata_o(i_rdata),
        .d_valid_i(d_valid), .d_ready_o(d_ready), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_we_i(d_we), .d_rdata_o(d_rdata),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata), .gnt_d_o(gnt_d)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) u0 (
        .clk(clk), .rst(rst),
        .i_valid_i(i_valid), .i_ready_o(z_i_ready), .i_addr_i(i_addr), .i_rdata_o(z_i_rdata),
        .d_valid_i(d_valid), .d_ready_o(z_d_ready), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_we_i(d_we), .d_rdata_o(z_d_rdata),
        .mem_valid_o(z_mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(z_mem_addr),
        .mem_wdata_o(z_mem_wdata), .mem_we_o(z_mem_we), .mem_rdata_i(mem_rdata), .gnt_d_o(z_gnt_d)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  dwe;
        logic        mr;
        logic [31:0] mrd;
        logic        e_mv;
        logic [31:0] e_ma;
        logic [31:0] e_mw;
        logic [3:0]  e_we;
        logic        e_ir;
        logic        e_dr;
        logic        e_g;
    } vec_t;

    vec_t vec [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                         input logic [31:0] dw, input logic [3:0] dwe, input logic mr, input logic [31:0] mrd);
        i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da;
        d_wdata = dw; d_we = dwe; mem_ready = mr; mem_rdata = mrd;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Table: test 1 fetch only, test 2 data lock, test 3 starvation, test 4 fetch drop,
        // then fetch redirect while locked and grant hold when idle.
        vec[0]  = '{1, 32'h100, 0, 32'h0, 32'h0, 4'h0, 1, 32'hAAAA0001, 1, 32'h100, 32'h0, 4'h0, 1, 0, 0};
        vec[1]  = '{0, 32'h300, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 1};
        vec[2]  = '{1, 32'h300, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 1};
        vec[3]  = '{1, 32'h300, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 1};
        vec[4]  = '{1, 32'h300, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h12345678, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 1, 1};
        vec[5]  = '{1, 32'h300, 0, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h87654321, 1, 32'h300, 32'h0, 4'h0, 1, 0, 0};
        for (int k = 0; k < 10; k++) begin
            logic g;
            g = (k % 5 == 4) ? 1'b0 : 1'b1;
            vec[6+k] = '{1, 32'h400, 1, 32'h3000, 32'h55, 4'h0, 1, 32'hC0DE0000 + k,
                         1, g ? 32'h3000 : 32'h400, g ? 32'h55 : 32'h0, 4'h0, !g, g, g};
        end
        vec[16] = '{1, 32'h500, 0, 32'h3000, 32'h0, 4'h0, 0, 32'h0, 1, 32'h500, 32'h0, 4'h0, 0, 0, 0};
        vec[17] = '{0, 32'h500, 1, 32'h3000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h500, 32'h0, 4'h0, 0, 0, 0};
        vec[18] = '{0, 32'h500, 1, 32'h3000, 32'h0, 4'h0, 1, 32'h0, 1, 32'h3000, 32'h0, 4'h0, 0, 1, 1};
        vec[19] = '{1, 32'h600, 0, 32'h3000, 32'h0, 4'h0, 0, 32'h0, 1, 32'h600, 32'h0, 4'h0, 0, 0, 0};
        vec[20] = '{1, 32'h640, 1, 32'h3000, 32'h0, 4'h0, 0, 32'h0, 1, 32'h640, 32'h0, 4'h0, 0, 0, 0};
        vec[21] = '{1, 32'h640, 1, 32'h3000, 32'h0, 4'h0, 1, 32'hFEED0000, 1, 32'h640, 32'h0, 4'h0, 1, 0, 0};
        vec[22] = '{0, 32'h0, 1, 32'h700, 32'h77, 4'h3, 1, 32'h0, 1, 32'h700, 32'h77, 4'h3, 0, 1, 1};
        vec[23] = '{0, 32'h0, 0, 32'h700, 32'h77, 4'h3, 0, 32'h0, 0, 32'h700, 32'h77, 4'h3, 0, 0, 1};

        // Outputs stay low while reset is held, even with requests and mem_ready high.
        #3;
        drive(1, 32'h10, 1, 32'h20, 0, 0, 1, 0);
        #1;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 24; n++) begin
            drive(vec[n].iv, vec[n].ia, vec[n].dv, vec[n].da, vec[n].dw, vec[n].dwe, vec[n].mr, vec[n].mrd);
            #2;
            check($sformatf("v%0d_mem_valid", n), mem_valid, vec[n].e_mv);
            check($sformatf("v%0d_mem_addr", n),  mem_addr,  vec[n].e_ma);
            check($sformatf("v%0d_mem_wdata", n), mem_wdata, vec[n].e_mw);
            check($sformatf("v%0d_mem_we", n),    mem_we,    vec[n].e_we);
            check($sformatf("v%0d_i_ready", n),   i_ready,   vec[n].e_ir);
            check($sformatf("v%0d_d_ready", n),   d_ready,   vec[n].e_dr);
            check($sformatf("v%0d_gnt_d", n),     gnt_d,     vec[n].e_g);
            check($sformatf("v%0d_i_rdata", n),   i_rdata,   vec[n].mrd);
            check($sformatf("v%0d_d_rdata", n),   d_rdata,   vec[n].mrd);
            @(posedge clk);
            #1;
        end

        // Reset pulse mid-LOCK_D: outputs drop immediately, no completion is reported.
        drive(0, 0, 1, 32'h800, 32'h1, 4'h1, 0, 0);
        @(posedge clk);
        #2;
        check("lockd_gnt_d", gnt_d, 1);
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_mem_valid", mem_valid, 0);
        check("midrst_d_ready", d_ready, 0);
        check("midrst_i_ready", i_ready, 0);
        #2 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Build a saturated streak, reset asynchronously, then a tie must go to data again.
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h900, 1, 32'hA00, 0, 0, 1, 0);
            #2;
            check($sformatf("streak_build%0d_gnt_d", k), gnt_d, 1);
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        #2;
        check("postrst_tie_gnt_d", gnt_d, 1);
        check("postrst_tie_d_ready", d_ready, 1);
        @(posedge clk);
        #1;

        // STARVE_LIMIT=0 instance: fetch wins every tie.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'hB00, 1, 32'hC00, 32'h5, 4'hF, 1, 32'h1234 + k);
            #2;
            check($sformatf("sl0_c%0d_gnt_d", k), z_gnt_d, 0);
            check($sformatf("sl0_c%0d_i_ready", k), z_i_ready, 1);
            check($sformatf("sl0_c%0d_d_ready", k), z_d_ready, 0);
            check($sformatf("sl0_c%0d_mem_addr", k), z_mem_addr, 32'hB00);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
